uart_parity_checker: RTL and testbench
======================================

# uart_parity_checker

Serial, parametrised parity checker for the UART receive path. It accumulates parity bit-by-bit as the receiver samples data bits, then checks the received parity bit against the selected mode. It reports the assembled word, a frame-done strobe, a parity-error strobe and a saturating error count. It sits between the receiver's bit-sampling logic and the receive data register, and replaces the former combinational 8-bit even/odd parity calculation.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9 supported)
- ERR_CNT_WIDTH, 8, width of the saturating parity-error counter
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- frame_start  input  1  one-cycle pulse at start-bit detection; (re)starts a frame
- bit_valid  input  1  one-cycle pulse: bit_in holds a sampled bit (data LSB first, then parity)
- bit_in  input  1  sampled serial bit
- parity_en  input  1  1 = frame carries a parity bit; sampled at frame_start
- parity_mode  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0); sampled at frame_start
- cnt_clear  input  1  synchronous clear of err_count
- data_out  output  DATA_WIDTH  assembled data word; updated only when done fires
- done  output  1  one-cycle pulse: frame complete, data_out valid
- parity_err  output  1  one-cycle pulse coincident with done when parity mismatched
- err_count  output  ERR_CNT_WIDTH  saturating count of parity errors

## Operation
- FSM states: IDLE, DATA, PARITY.
- IDLE: bit_valid ignored. On frame_start: latch parity_en/parity_mode, clear shift register, bit counter and XOR accumulator, go to DATA.
- DATA: each bit_valid shifts bit_in into the MSB of the shift register (LSB-first reception), XORs it into the accumulator and increments the bit counter. On the DATA_WIDTH-th bit, go to PARITY if parity_en, else go to IDLE and fire done (parity_err = 0).
- PARITY: the next bit_valid compares bit_in with the expected bit. Expected bit is acc for even, ~acc for odd, 1 for mark, 0 for space. Then fire done; fire parity_err on mismatch; go to IDLE.
- frame_start in DATA or PARITY aborts the current frame without done or parity_err, and restarts it exactly as from IDLE.
- frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.
- err_count increments on each parity_err and holds at all-ones. If cnt_clear and parity_err coincide, clear wins and the count becomes 0.
- parity_mode/parity_en changes mid-frame have no effect until the next frame_start.

## Timing
- Reset values: data_out = 0, done = 0, parity_err = 0, err_count = 0, FSM = IDLE, accumulator/counter = 0.
- done, parity_err and data_out are registered. They assert the cycle after the final bit_valid (last data bit or parity bit).
- data_out holds until the next done. done/parity_err are high for exactly one cycle.
- Back-to-back: frame_start in the cycle done is high is legal and accepted.
- Reset asserted mid-frame returns all state to reset values immediately. No done is issued for the interrupted frame.
- Minimum spacing of bit_valid pulses: 1 cycle (consecutive-cycle pulses are legal).

## Configuration
- UART_PARITY_ERR_COUNT_EN
  - Defined: err_count and its saturating counter are present, and cnt_clear is functional.
  - Not defined: err_count is tied to 0, cnt_clear is ignored, and no counter logic is synthesised.
  - The port list is identical in both cases.

## Structure
- Shared package uart_pkg holds:
  - parity-mode encodings PAR_EVEN / PAR_ODD / PAR_MARK / PAR_SPACE
  - the FSM state typedef
  - the default DATA_WIDTH constant
- One sub-module, parity_accumulator, holds the bit counter, XOR accumulator and shift register. It has load/shift controls and a last_bit flag. The FSM and error logic stay in the top.

## Test plan
- Even mode: frame 0xA5 (bits 1,0,1,0,0,1,0,1), parity bit 0 -> done 1 cycle after parity bit, data_out = 0xA5, parity_err = 0, err_count = 0.
- Odd mode: frame 0xA5, parity bit 0 -> parity_err pulse with done, err_count = 1. Then cnt_clear -> err_count = 0.
- parity_en = 0: frame 0x3C -> done 1 cycle after 8th data bit, parity_err = 0. A following bit_valid before frame_start is ignored.
- Abort: frame_start, 3 data bits, frame_start again, then 0xFF in even mode with parity 0 -> single done, data_out = 0xFF, no error.
- Mark mode: frame 0x00 with parity 0 -> parity_err. Space mode: frame 0x00 with parity 0 -> no error.
- Saturation (ERR_CNT_WIDTH = 8): 300 odd-mode error frames -> err_count stops at 255. Reset mid-frame -> all outputs 0, no done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-path parity checker: parity-mode
// encodings, FSM state type and the default data width.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10
  } uart_state_e;

  // The parity bit the transmitter should have sent, given the XOR of the data bits.
  function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
    logic exp_bit;
    exp_bit = 1'b0;
    case (mode)
      PAR_EVEN:  exp_bit = acc;
      PAR_ODD:   exp_bit = ~acc;
      PAR_MARK:  exp_bit = 1'b1;
      PAR_SPACE: exp_bit = 1'b0;
      default:   exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/parity_accumulator.sv
// Bit counter, running XOR and LSB-first shift register for one received frame.
// load clears everything; shift takes one data bit.
module parity_accumulator
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  bit_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic [DATA_WIDTH-1:0] word_next_o,
  output logic                  acc_o,
  output logic                  last_bit_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  acc_q, acc_d;

  // New bits enter at the MSB so the first (LSB) bit lands at bit 0 after DATA_WIDTH shifts.
  assign word_next_o = {bit_i, shreg_q[DATA_WIDTH-1:1]};
  assign word_o      = shreg_q;
  assign acc_o       = acc_q;
  assign last_bit_o  = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (load_i) begin
      shreg_d = '0;
      cnt_d   = '0;
      acc_d   = 1'b0;
    end else if (shift_i) begin
      shreg_d = word_next_o;
      cnt_d   = cnt_q + CNT_W'(1);
      acc_d   = acc_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/uart_parity_checker.sv
// Serial UART parity checker: assembles a frame bit by bit and checks its parity bit.
// Optional saturating error counter enabled by UART_PARITY_ERR_COUNT_EN.
module uart_parity_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     parity_en,
  input  logic [1:0]               parity_mode,
  input  logic                     cnt_clear,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     done,
  output logic                     parity_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  uart_state_e           state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  parity_err_q, parity_err_d;

  logic                  acc_load, acc_shift;
  logic [DATA_WIDTH-1:0] word, word_next;
  logic                  acc, last_bit;

  parity_accumulator #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_acc (
    .clk         (clk),
    .rst         (reset),
    .load_i      (acc_load),
    .shift_i     (acc_shift),
    .bit_i       (bit_in),
    .word_o      (word),
    .word_next_o (word_next),
    .acc_o       (acc),
    .last_bit_o  (last_bit)
  );

  // frame_start overrides everything, including a bit_valid in the same cycle.
  always_comb begin
    state_d      = state_q;
    par_en_d     = par_en_q;
    par_mode_d   = par_mode_q;
    data_d       = data_q;
    done_d       = 1'b0;
    parity_err_d = 1'b0;
    acc_load     = 1'b0;
    acc_shift    = 1'b0;
    if (frame_start) begin
      acc_load   = 1'b1;
      par_en_d   = parity_en;
      par_mode_d = parity_mode;
      state_d    = ST_DATA;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (bit_valid) begin
            acc_shift = 1'b1;
            if (last_bit) begin
              if (par_en_q) begin
                state_d = ST_PARITY;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                data_d  = word_next;
              end
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            data_d       = word;
            parity_err_d = bit_in ^ expected_parity(par_mode_q, acc);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      par_en_q     <= 1'b0;
      par_mode_q   <= PAR_EVEN;
      data_q       <= '0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      par_mode_q   <= par_mode_d;
      data_q       <= data_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_q;
  assign done       = done_q;
  assign parity_err = parity_err_q;

`ifdef UART_PARITY_ERR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Counts the visible parity_err pulse; a clear in that same cycle wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clear) begin
      err_cnt_d = '0;
    end else if (parity_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign err_count        = '0;
`endif

endmodule

// File: tb/tb_uart_parity_checker.sv
// Directed bench for uart_parity_checker: table of frames plus hand-written
// sequences for abort, back-to-back, same-cycle start, saturation and reset.
module tb_uart_parity_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       bit_valid;
  logic       bit_in;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       cnt_clear;
  logic [7:0] data_out;
  logic       done;
  logic       parity_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  uart_parity_checker #(
    .DATA_WIDTH    (8),
    .ERR_CNT_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .parity_en   (parity_en),
    .parity_mode (parity_mode),
    .cnt_clear   (cnt_clear),
    .data_out    (data_out),
    .done        (done),
    .parity_err  (parity_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       pen;
    logic [1:0] mode;
    logic       pbit;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_err_count();
`ifdef UART_PARITY_ERR_COUNT_EN
    return 8'(exp_cnt);
`else
    return 8'h00;
`endif
  endfunction

  function automatic void model_err(input logic e);
    if (e && exp_cnt < 255) exp_cnt++;
  endfunction

  // Returns at the falling edge where done for this frame must be visible.
  // Mode/enable inputs are scrambled after frame_start to show they are latched.
  task automatic drive_frame(input logic [7:0] word, input logic pen, input logic [1:0] mode,
                             input logic pbit, input logic start_now, input logic bv_on_start);
    if (!start_now) @(negedge clk);
    frame_start = 1'b1;
    parity_en   = pen;
    parity_mode = mode;
    bit_valid   = bv_on_start;
    bit_in      = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    parity_en   = ~pen;
    parity_mode = ~mode;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = word[i];
      @(negedge clk);
    end
    if (pen) begin
      bit_valid = 1'b1;
      bit_in    = pbit;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    parity_en   = 1'b0;
    parity_mode = 2'b00;
    cnt_clear   = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b0}; // even ok
    vecs[1] = '{8'hA5, 1'b1, 2'b01, 1'b0, 8'hA5, 1'b1}; // odd error
    vecs[2] = '{8'h3C, 1'b0, 2'b00, 1'b0, 8'h3C, 1'b0}; // no parity
    vecs[3] = '{8'h00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b1}; // mark error
    vecs[4] = '{8'h00, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0}; // space ok
    vecs[5] = '{8'hFF, 1'b1, 2'b00, 1'b0, 8'hFF, 1'b0}; // even ok
    vecs[6] = '{8'h01, 1'b1, 2'b00, 1'b1, 8'h01, 1'b0}; // even ok
    vecs[7] = '{8'h01, 1'b1, 2'b01, 1'b1, 8'h01, 1'b1}; // odd error
    vecs[8] = '{8'h80, 1'b1, 2'b11, 1'b1, 8'h80, 1'b1}; // space error
    vecs[9] = '{8'h7F, 1'b1, 2'b10, 1'b1, 8'h7F, 1'b0}; // mark ok

    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_cnt", 32'(err_count), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Table frames
    for (int v = 0; v < 10; v++) begin
      drive_frame(vecs[v].word, vecs[v].pen, vecs[v].mode, vecs[v].pbit, 1'b0, 1'b0);
      check($sformatf("v%0d_done", v), 32'(done), 32'h1);
      check($sformatf("v%0d_data", v), 32'(data_out), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_perr", v), 32'(parity_err), 32'(vecs[v].exp_err));
      model_err(vecs[v].exp_err);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 32'(done), 32'h0);
      check($sformatf("v%0d_perr_pulse", v), 32'(parity_err), 32'h0);
      check($sformatf("v%0d_cnt", v), 32'(err_count), 32'(exp_err_count()));
    end

    // Counter clear
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_cnt   = 0;
    check("clr_cnt", 32'(err_count), 32'(exp_err_count()));

    // Stray bit_valid after a no-parity frame is ignored
    drive_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("np_done", 32'(done), 32'h1);
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
      check($sformatf("stray_done%0d", i), 32'(done), 32'h0);
    end
    bit_valid = 1'b0;
    check("stray_data_hold", 32'(data_out), 32'h3C);

    // Abort after 3 bits, then restart
    frame_start = 1'b1;
    parity_en   = 1'b1;
    parity_mode = 2'b01;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    check("abort_nodone", 32'(done), 32'h0);
    drive_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("abort_done", 32'(done), 32'h1);
    check("abort_data", 32'(data_out), 32'hFF);
    check("abort_perr", 32'(parity_err), 32'h0);
    @(negedge clk);
    check("abort_single", 32'(done), 32'h0);

    // frame_start with bit_valid in the same cycle: bit discarded
    drive_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    check("same_done", 32'(done), 32'h1);
    check("same_data", 32'(data_out), 32'h00);
    check("same_perr", 32'(parity_err), 32'h0);

    // Back-to-back: next frame_start while done is high
    drive_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("b2b_done1", 32'(done), 32'h1);
    check("b2b_data1", 32'(data_out), 32'h5A);
    drive_frame(8'hC3, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    check("b2b_done2", 32'(done), 32'h1);
    check("b2b_data2", 32'(data_out), 32'hC3);
    check("b2b_perr2", 32'(parity_err), 32'h0);
    @(negedge clk);
    check("b2b_cnt", 32'(err_count), 32'(exp_err_count()));

    // Saturation: 300 odd-mode error frames
    for (int f = 0; f < 300; f++) begin
      drive_frame(8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      if (f == 0) check("sat_perr0", 32'(parity_err), 32'h1);
      model_err(1'b1);
    end
    @(negedge clk);
    check("sat_cnt", 32'(err_count), 32'(exp_err_count()));
    @(negedge clk);
    check("sat_hold", 32'(err_count), 32'(exp_err_count()));

    // cnt_clear coincident with parity_err: clear wins
    drive_frame(8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    check("coin_perr", 32'(parity_err), 32'h1);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_cnt   = 0;
    check("coin_cnt", 32'(err_count), 32'(exp_err_count()));

    // Leave an error count and data behind, then reset mid-frame
    drive_frame(8'h96, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    check("pre_rst_data", 32'(data_out), 32'h96);
    model_err(1'b1);
    frame_start = 1'b1;
    parity_en   = 1'b1;
    parity_mode = 2'b00;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_perr", 32'(parity_err), 32'h0);
    check("mid_rst_cnt", 32'(err_count), 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
      check($sformatf("post_rst_nodone%0d", i), 32'(done), 32'h0);
    end
    bit_valid = 1'b0;
    drive_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("post_rst_done", 32'(done), 32'h1);
    check("post_rst_data", 32'(data_out), 32'h3C);
    check("post_rst_perr", 32'(parity_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
